column_select_ctrl: RTL and testbench
=====================================

Name: column_select_ctrl

Overview:
- Converts synchronized button events into the Connect-4 cursor column and drop requests.
- Inputs: one-cycle press pulses and synchronized active-low levels for the left, right and drop buttons, taken from the per-button synchronizer/edge-detector instances.
- Sequences auto-repeat on held left/right buttons and arbitrates simultaneous presses.
- Issues a req/ack-handshaked drop request to the game-logic FSM.

Parameters:
- COLS, 7, number of board columns; column index range 0..COLS-1.
- REPEAT_DELAY, 25000000, clk cycles a left/right button must be held before the first auto-repeat step.
- REPEAT_RATE, 5000000, clk cycles between subsequent auto-repeat steps.
- CW, $clog2(COLS), column index width (derived, not overridable).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  game accepts player input; 0 = ignore all buttons.
- left_pulse  in  1  one-cycle press event for the left button.
- right_pulse  in  1  one-cycle press event for the right button.
- drop_pulse  in  1  one-cycle press event for the drop button.
- left_level  in  1  synchronized left button level; 0 = pressed.
- right_level  in  1  synchronized right button level; 0 = pressed.
- drop_ack  in  1  game logic has accepted the drop.
- col  out  CW  current cursor column.
- drop_req  out  1  drop request; held until acknowledged.
- drop_col  out  CW  column latched for the drop; stable while drop_req=1.
- busy  out  1  drop handshake in progress.

Behaviour:
- Reset (rst=0, async): state=IDLE, col=COLS/2 (3 for COLS=7), drop_req=0, drop_col=0, busy=0, repeat counter=0, dir=left. All outputs are registered.
- Step rule, left: col <= (col==0) ? COLS-1 : col-1.
- Step rule, right: col <= (col==COLS-1) ? 0 : col+1.
- Step latency: a step triggered by a pulse sampled at edge N makes col change at edge N+1 (visible one cycle after the pulse).
- Arbitration, same cycle: drop > left/right.
- Arbitration, left_pulse and right_pulse together without drop: both ignored; col unchanged; state unchanged.
- IDLE, enable=0: all pulses ignored.
- IDLE, drop_pulse: drop_req<=1, drop_col<=col, busy<=1, go to DROP_WAIT.
- IDLE, single left or right pulse: one step; dir<=that direction; counter<=0; go to HOLD_DELAY.
- HOLD_DELAY: counter increments each cycle. When counter==REPEAT_DELAY-1: one step in dir, counter<=0, go to HOLD_REPEAT.
- HOLD_REPEAT: counter increments each cycle. When counter==REPEAT_RATE-1: one step in dir, counter<=0. Repeats indefinitely; col wraps per the step rule.
- Exit to IDLE from HOLD_*: the held level of dir goes 1 (release), or enable goes 0. No step in that cycle; counter<=0.
- HOLD_*, opposite-direction pulse: ignored.
- HOLD_*, drop_pulse: aborts the hold and takes the IDLE drop action, latching the current col.
- HOLD_*, release and drop in the same cycle: drop wins.
- DROP_WAIT: drop_req and drop_col stay stable. All button pulses are ignored, including new drops; col is frozen. enable is ignored (the handshake always completes).
- DROP_WAIT, drop_ack=1 sampled: next edge drop_req<=0, busy<=0, state IDLE.
- drop_ack while drop_req=0: ignored.
- Minimum handshake: ack in the first cycle drop_req is high -> drop_req high for exactly 1 cycle.
- Reset asserted mid-hold or mid-handshake: immediate return to reset values; any pending drop is lost.
- Counter width: $clog2(max(REPEAT_DELAY, REPEAT_RATE)). The counter never exceeds its terminal value.

Test Plan:
- Wrap (COLS=7, REPEAT_DELAY=8, REPEAT_RATE=4, enable=1): after reset col=3; 4 separated left pulses, each released before repeat -> col 2,1,0,6; each update 1 cycle after its pulse.
- Auto-repeat: right_pulse with right_level held 0 for 20 cycles starting at col=3 -> col=4 at +1; 5 at +9; 6 at +13; 0 at +17 (wrap); 1 at +21 only if still held. Release -> IDLE, no further change.
- Arbitration: left_pulse+right_pulse same cycle -> col unchanged, state IDLE. left_pulse+drop_pulse same cycle -> drop_req=1, drop_col=3, col stays 3.
- Handshake: drop_pulse at col=5 -> drop_req=1, busy=1, drop_col=5. Pulses during wait change nothing. drop_ack held 0 for 10 cycles keeps the request; drop_ack=1 for 1 cycle -> drop_req=0, busy=0 on the next edge.
- Enable gating: enable=0 with left/drop pulses -> no change. enable falls mid-HOLD_REPEAT -> IDLE, no further steps after release or re-enable.
- Reset mid-operation: rst=0 during DROP_WAIT at col=6 -> drop_req=0, busy=0, col=3 immediately (asynchronous); a late drop_ack after reset is ignored.

Source files
------------

// File: rtl/column_select_ctrl.sv
// column_select_ctrl: turns synchronized button events into the Connect-4 cursor
// column (with held-button auto-repeat) and a req/ack drop request to game logic.
// Latency: a step or drop taken from a pulse is visible one cycle after that pulse; all outputs registered.
// Backpressure: while a drop is outstanding (drop_req=1) every button is ignored until drop_ack.
//
// Ports:
//   clk, rst (async active-low)       clock / reset
//   enable                            0 = ignore all buttons (an open drop handshake still completes)
//   left/right/drop_pulse             one-cycle press events
//   left/right_level                  synchronized levels, 0 = pressed
//   drop_ack                          game logic accepted the drop
//   col, drop_req, drop_col, busy     cursor column, drop handshake outputs
module column_select_ctrl #(
    parameter int COLS         = 7,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    localparam int CW          = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          left_pulse,
    input  logic          right_pulse,
    input  logic          drop_pulse,
    input  logic          left_level,
    input  logic          right_level,
    input  logic          drop_ack,
    output logic [CW-1:0] col,
    output logic          drop_req,
    output logic [CW-1:0] drop_col,
    output logic          busy
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNTW-1:0] DELAY_TERM = CNTW'(REPEAT_DELAY - 1);
    localparam logic [CNTW-1:0] RATE_TERM  = CNTW'(REPEAT_RATE - 1);
    localparam logic [CW-1:0]   COL_LAST   = CW'(COLS - 1);
    localparam logic [CW-1:0]   COL_HOME   = CW'(COLS / 2);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2,
        DROP_WAIT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [CW-1:0]     drop_col_q, drop_col_d;
    logic              drop_req_q, drop_req_d;
    logic              busy_q, busy_d;
    logic              dir_q, dir_d;          // 0 = left, 1 = right
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic              single_pulse;
    logic              held_released;
    logic [CNTW-1:0]   cnt_term;

    // Cursor movement with wrap-around at both board edges.
    function automatic logic [CW-1:0] step_col(input logic [CW-1:0] c, input logic to_right);
        if (to_right) begin
            return (c == COL_LAST) ? '0 : c + 1'b1;
        end
        return (c == '0) ? COL_LAST : c - 1'b1;
    endfunction

    // Simultaneous left+right is treated as no press at all.
    assign single_pulse  = left_pulse ^ right_pulse;
    assign held_released = dir_q ? right_level : left_level;
    assign cnt_term      = (state_q == HOLD_DELAY) ? DELAY_TERM : RATE_TERM;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        drop_col_d = drop_col_q;
        drop_req_d = drop_req_q;
        busy_d     = busy_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (drop_pulse) begin
                        drop_req_d = 1'b1;
                        busy_d     = 1'b1;
                        drop_col_d = col_q;
                        cnt_d      = '0;
                        state_d    = DROP_WAIT;
                    end else if (single_pulse) begin
                        col_d   = step_col(col_q, right_pulse);
                        dir_d   = right_pulse;
                        cnt_d   = '0;
                        state_d = HOLD_DELAY;
                    end
                end
            end

            HOLD_DELAY, HOLD_REPEAT: begin
                // Priority: drop aborts the hold, then release/disable, then repeat timing.
                // Any new left/right pulse is ignored while holding.
                if (enable && drop_pulse) begin
                    drop_req_d = 1'b1;
                    busy_d     = 1'b1;
                    drop_col_d = col_q;
                    cnt_d      = '0;
                    state_d    = DROP_WAIT;
                end else if (!enable || held_released) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == cnt_term) begin
                    col_d   = step_col(col_q, dir_q);
                    cnt_d   = '0;
                    state_d = HOLD_REPEAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DROP_WAIT: begin
                // Cursor frozen and enable ignored: the handshake always runs to completion.
                if (drop_ack) begin
                    drop_req_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            col_q      <= COL_HOME;
            drop_col_q <= '0;
            drop_req_q <= 1'b0;
            busy_q     <= 1'b0;
            dir_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            drop_col_q <= drop_col_d;
            drop_req_q <= drop_req_d;
            busy_q     <= busy_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
        end
    end

    assign col      = col_q;
    assign drop_req = drop_req_q;
    assign drop_col = drop_col_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_column_select_ctrl.sv
// Bench for column_select_ctrl with short repeat timing (COLS=7, delay 8, rate 4).
// Table vectors, directed multi-cycle sequences, then random stimulus against a reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_column_select_ctrl;

    localparam int COLS = 7;
    localparam int RD   = 8;
    localparam int RR   = 4;
    localparam int CW   = $clog2(COLS);

    logic          clk = 1'b0;
    logic          rst;
    logic          enable, left_pulse, right_pulse, drop_pulse;
    logic          left_level, right_level, drop_ack;
    logic [CW-1:0] col, drop_col;
    logic          drop_req, busy;

    int n_total = 0;
    int n_pass  = 0;

    column_select_ctrl #(.COLS(COLS), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .left_pulse (left_pulse),
        .right_pulse(right_pulse),
        .drop_pulse (drop_pulse),
        .left_level (left_level),
        .right_level(right_level),
        .drop_ack   (drop_ack),
        .col        (col),
        .drop_req   (drop_req),
        .drop_col   (drop_col),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: cursor + press timing, not a state machine copy
    int m_col, m_dcol, m_held, m_t;   // m_held: -1 none, 0 left, 1 right; m_t: edges since press
    bit m_req, m_busy;

    function automatic int move(input int c, input int to_right);
        return to_right ? (c + 1) % COLS : (c + COLS - 1) % COLS;
    endfunction

    task automatic model_reset();
        m_col = COLS / 2; m_dcol = 0; m_req = 0; m_busy = 0; m_held = -1; m_t = 0;
    endtask

    task automatic model_step();
        if (m_req) begin
            if (drop_ack) begin m_req = 0; m_busy = 0; end
        end else if (m_held >= 0) begin
            if (enable && drop_pulse) begin
                m_req = 1; m_busy = 1; m_dcol = m_col; m_held = -1;
            end else if (!enable || (m_held == 1 ? right_level : left_level)) begin
                m_held = -1;
            end else begin
                m_t++;
                // first repeat RD edges after the press, then every RR edges
                if (m_t == RD || (m_t > RD && (m_t - RD) % RR == 0))
                    m_col = move(m_col, m_held);
            end
        end else if (enable) begin
            if (drop_pulse) begin
                m_req = 1; m_busy = 1; m_dcol = m_col;
            end else if (left_pulse != right_pulse) begin
                m_col = move(m_col, right_pulse ? 1 : 0);
                m_held = right_pulse ? 1 : 0;
                m_t = 0;
            end
        end
    endtask

    // ---------------- helpers
    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_all(input string tag, input int c, input int r, input int dc, input int b);
        chk({tag, ".col"},      int'(col),      c);
        chk({tag, ".drop_req"}, int'(drop_req), r);
        chk({tag, ".drop_col"}, int'(drop_col), dc);
        chk({tag, ".busy"},     int'(busy),     b);
    endtask

    task automatic drive(input logic en, input logic lp, input logic rp, input logic dp,
                         input logic ll, input logic rl, input logic ack);
        enable = en; left_pulse = lp; right_pulse = rp; drop_pulse = dp;
        left_level = ll; right_level = rl; drop_ack = ack;
    endtask

    task automatic idle_inputs();
        drive(1, 0, 0, 0, 1, 1, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table
    typedef struct {
        logic en, lp, rp, dp, ll, rl, ack;
        int   col;
        logic req;
        int   dcol;
        logic bsy;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic en, input logic lp, input logic rp, input logic dp,
                                input logic ll, input logic rl, input logic ack,
                                input int c, input logic r, input int dc, input logic b);
        vec_t v;
        v.en = en; v.lp = lp; v.rp = rp; v.dp = dp; v.ll = ll; v.rl = rl; v.ack = ack;
        v.col = c; v.req = r; v.dcol = dc; v.bsy = b;
        return v;
    endfunction

    initial begin
        //            en lp rp dp ll rl ack  col req dcol busy
        vecs[0]  = mk(1, 1, 0, 0, 0, 1, 0,   2, 0, 0, 0);  // left press
        vecs[1]  = mk(1, 0, 0, 0, 1, 1, 0,   2, 0, 0, 0);  // release
        vecs[2]  = mk(1, 1, 0, 0, 0, 1, 0,   1, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0, 1, 1, 0,   1, 0, 0, 0);
        vecs[4]  = mk(1, 1, 0, 0, 0, 1, 0,   0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0);
        vecs[6]  = mk(1, 1, 0, 0, 0, 1, 0,   6, 0, 0, 0);  // wrap 0 -> 6
        vecs[7]  = mk(1, 0, 0, 0, 1, 1, 0,   6, 0, 0, 0);
        vecs[8]  = mk(1, 1, 1, 0, 0, 0, 0,   6, 0, 0, 0);  // left+right ignored
        vecs[9]  = mk(1, 0, 0, 0, 1, 1, 0,   6, 0, 0, 0);
        vecs[10] = mk(1, 0, 1, 0, 1, 0, 0,   0, 0, 0, 0);  // wrap 6 -> 0
        vecs[11] = mk(1, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0);
        vecs[12] = mk(0, 1, 0, 0, 0, 1, 0,   0, 0, 0, 0);  // disabled left
        vecs[13] = mk(0, 0, 0, 1, 1, 1, 0,   0, 0, 0, 0);  // disabled drop
        vecs[14] = mk(1, 1, 0, 1, 1, 1, 0,   0, 1, 0, 1);  // drop beats left
        vecs[15] = mk(1, 0, 1, 0, 1, 0, 0,   0, 1, 0, 1);  // right ignored in wait
        vecs[16] = mk(1, 0, 0, 0, 1, 1, 1,   0, 0, 0, 0);  // ack
        vecs[17] = mk(1, 0, 0, 0, 1, 1, 1,   0, 0, 0, 0);  // stray ack ignored
        vecs[18] = mk(1, 0, 1, 0, 1, 0, 0,   1, 0, 0, 0);  // right press, hold
        vecs[19] = mk(1, 0, 1, 1, 1, 0, 0,   1, 1, 1, 1);  // drop aborts hold
        vecs[20] = mk(1, 0, 0, 0, 1, 1, 1,   1, 0, 1, 0);
    end

    // ---------------- main sequence
    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #2 rst = 1'b0;
        #1 chk_all("reset", 3, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 chk_all("reset_release", 3, 0, 0, 0);

        // table
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].en, vecs[i].lp, vecs[i].rp, vecs[i].dp, vecs[i].ll, vecs[i].rl, vecs[i].ack);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].col, vecs[i].req, vecs[i].dcol, vecs[i].bsy);
        end

        // auto-repeat from col 3
        do_reset();
        drive(1, 0, 1, 0, 1, 0, 0);
        tick();
        chk("rep+1", int'(col), 4);
        drive(1, 0, 0, 0, 1, 0, 0);
        for (int k = 2; k <= 21; k++) begin
            tick();
            if (k == 8)  chk("rep+8",  int'(col), 4);
            if (k == 9)  chk("rep+9",  int'(col), 5);
            if (k == 12) chk("rep+12", int'(col), 5);
            if (k == 13) chk("rep+13", int'(col), 6);
            if (k == 17) chk("rep+17", int'(col), 0);
            if (k == 21) chk("rep+21", int'(col), 1);
        end
        drive(1, 0, 0, 0, 1, 1, 0);
        for (int k = 0; k < 10; k++) tick();
        chk("rep_released", int'(col), 1);

        // enable drops during HOLD_REPEAT
        drive(1, 0, 1, 0, 1, 0, 0);
        tick();
        chk("en_hold+1", int'(col), 2);
        drive(1, 0, 0, 0, 1, 0, 0);
        for (int k = 2; k <= 10; k++) tick();
        chk("en_hold+10", int'(col), 3);
        drive(0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 6; k++) tick();
        chk("en_off", int'(col), 3);
        drive(1, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 12; k++) tick();
        chk("en_back_on", int'(col), 3);

        // handshake at col 5 with a long ack stall
        do_reset();
        for (int s = 0; s < 2; s++) begin
            drive(1, 0, 1, 0, 1, 0, 0); tick();
            drive(1, 0, 0, 0, 1, 1, 0); tick();
        end
        chk("hs_col", int'(col), 5);
        drive(1, 0, 0, 1, 1, 1, 0);
        tick();
        chk_all("hs_req", 5, 1, 5, 1);
        for (int k = 0; k < 10; k++) begin
            drive(k[0], ~k[0], k[0], k[1], k[0], ~k[0], 0);
            tick();
        end
        chk_all("hs_stall", 5, 1, 5, 1);
        drive(1, 0, 0, 0, 1, 1, 1);
        tick();
        chk_all("hs_ack", 5, 0, 5, 0);
        drive(1, 0, 0, 0, 1, 1, 0);
        tick();
        chk_all("hs_idle", 5, 0, 5, 0);

        // minimum handshake: one cycle of drop_req
        drive(1, 0, 0, 1, 1, 1, 0);
        tick();
        chk("min_req_hi", int'(drop_req), 1);
        drive(1, 0, 0, 0, 1, 1, 1);
        tick();
        chk("min_req_lo", int'(drop_req), 0);

        // async reset during a pending drop at col 6
        drive(1, 0, 1, 0, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 1, 1, 0); tick();
        drive(1, 0, 0, 1, 1, 1, 0); tick();
        chk_all("rst_pre", 6, 1, 6, 1);
        idle_inputs();
        #2 rst = 1'b0;
        model_reset();
        #1 chk_all("rst_async", 3, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_all("rst_late_ack", 3, 0, 0, 0);

        // random stimulus against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(15) == 0) left_level  = ~left_level;
            if ($urandom_range(15) == 0) right_level = ~right_level;
            if ($urandom_range(63) == 0) enable      = ~enable;
            left_pulse  = ($urandom_range(9) == 0);
            right_pulse = ($urandom_range(9) == 0);
            drop_pulse  = ($urandom_range(29) == 0);
            drop_ack    = ($urandom_range(3) == 0);
            tick();
            chk_all("rnd", m_col, int'(m_req), m_dcol, int'(m_busy));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
